// File: rtl/cnn_l2_result_reader.sv
// cnn_l2_result_reader: reads L2 class scores after the engine goes idle,
// streams them over valid/ready and reports the signed argmax class.
module cnn_l2_result_reader #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              busy,
  output logic              oe_L2,
  output logic [ADDR_W-1:0] addr_L2,
  input  logic [DATA_W-1:0] r_data_L2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic [ADDR_W-1:0] class_id,
  output logic [DATA_W-1:0] class_score,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_READ,
    S_CAP,
    S_SEND,
    S_FIN
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                oe_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                valid_q;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]   oidx_q;
  logic                last_q;
  logic [DATA_W-1:0]   max_q;
  logic [ADDR_W-1:0]   max_id_q;
  logic [ADDR_W-1:0]   cls_id_q;
  logic [DATA_W-1:0]   cls_score_q;
  logic                done_q;

  logic                take;
  logic [DATA_W-1:0]   max_d;
  logic [ADDR_W-1:0]   max_id_d;
  logic [ADDR_W-1:0]   idx_d;

  // Running-max candidate for the beat currently offered on the stream;
  // entry 0 always loads, later ones only when strictly greater (signed).
  always_comb begin
    take     = 1'b0;
    max_d    = max_q;
    max_id_d = max_id_q;
    idx_d    = idx_q + 1'b1;
    if (oidx_q == '0) begin
      take = 1'b1;
    end else if ($signed(data_q) > $signed(max_q)) begin
      take = 1'b1;
    end
    if (take) begin
      max_d    = data_q;
      max_id_d = oidx_q;
    end
  end

  // Run sequencer with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      oe_q        <= 1'b0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      oidx_q      <= '0;
      last_q      <= 1'b0;
      max_q       <= '0;
      max_id_q    <= '0;
      cls_id_q    <= '0;
      cls_score_q <= '0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (busy) begin
            state_q <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (!busy) begin
            state_q <= S_READ;
            idx_q   <= '0;
            oe_q    <= 1'b1;
            addr_q  <= '0;
          end
        end
        S_READ: begin
          oe_q    <= 1'b0;
          state_q <= S_CAP;
        end
        S_CAP: begin
          data_q  <= r_data_L2;
          oidx_q  <= idx_q;
          last_q  <= (idx_q == LAST);
          valid_q <= 1'b1;
          state_q <= S_SEND;
        end
        S_SEND: begin
          if (valid_q && out_ready) begin
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            max_q    <= max_d;
            max_id_q <= max_id_d;
            if (last_q) begin
              state_q     <= S_FIN;
              done_q      <= 1'b1;
              cls_id_q    <= max_id_d;
              cls_score_q <= max_d;
            end else begin
              idx_q   <= idx_d;
              oe_q    <= 1'b1;
              addr_q  <= idx_d;
              state_q <= S_READ;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          oe_q    <= 1'b0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oe_L2       = oe_q;
  assign addr_L2     = addr_q;
  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_idx     = oidx_q;
  assign out_last    = last_q;
  assign class_id    = cls_id_q;
  assign class_score = cls_score_q;
  assign done        = done_q;

endmodule

// File: tb/tb_cnn_l2_result_reader.sv
// tb_cnn_l2_result_reader: directed scenarios for the L2 result reader,
// with an L2 memory model and a stream monitor.
module tb_cnn_l2_result_reader;

  localparam int NC = 10;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          busy = 1'b0;
  logic          oe_L2;
  logic [AW-1:0] addr_L2;
  logic [DW-1:0] r_data_L2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;
  logic [AW-1:0] class_id;
  logic [DW-1:0] class_score;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [16];
  bit            rand_mode = 1'b0;

  logic [DW-1:0] beat_data [$];
  logic [AW-1:0] beat_idx  [$];
  logic          beat_last [$];
  logic [AW-1:0] oe_addr   [$];
  int            done_n = 0;
  int            stab_err = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [AW-1:0] prev_idx = '0;

  cnn_l2_result_reader #(
    .NUM_CLASSES(NC),
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .busy(busy),
    .oe_L2(oe_L2),
    .addr_L2(addr_L2),
    .r_data_L2(r_data_L2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_idx(out_idx),
    .out_last(out_last),
    .class_id(class_id),
    .class_score(class_score),
    .done(done)
  );

  always #5 clk = ~clk;

  // L2 memory: data valid the cycle after oe_L2
  always @(posedge clk) begin
    if (oe_L2) r_data_L2 <= mem[addr_L2];
  end

  // random back-pressure driver
  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      out_ready = ($urandom_range(0, 9) < 3);
    end
  end

  // stream / read monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (oe_L2) oe_addr.push_back(addr_L2);
    if (done) done_n++;
    if (prev_hold) begin
      if (!out_valid || out_data != prev_data || out_idx != prev_idx)
        stab_err++;
    end
    if (out_valid && out_ready) begin
      beat_data.push_back(out_data);
      beat_idx.push_back(out_idx);
      beat_last.push_back(out_last);
    end
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
    prev_idx  = out_idx;
  end

  task automatic clear_stats();
    beat_data.delete();
    beat_idx.delete();
    beat_last.delete();
    oe_addr.delete();
    done_n   = 0;
    stab_err = 0;
  endtask

  task automatic load(input int s [NC]);
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < NC; i++) mem[i] = s[i];
  endtask

  task automatic start_and_wait(output int cyc, output bit ok);
    busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    busy = 1'b0;
    cyc = 0;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag);
    n_checks++;
    if (beat_data.size() != NC) begin
      n_fail++;
      $display("FAIL %s beats: got %0d want %0d", tag, beat_data.size(), NC);
    end
    n_checks++;
    if (oe_addr.size() != NC) begin
      n_fail++;
      $display("FAIL %s oe_pulses: got %0d want %0d", tag, oe_addr.size(), NC);
    end
    for (int i = 0; i < beat_data.size() && i < NC; i++) begin
      n_checks++;
      if (beat_idx[i] !== AW'(i) || beat_data[i] !== mem[i] ||
          beat_last[i] !== (i == NC - 1)) begin
        n_fail++;
        $display("FAIL %s beat%0d: got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                 tag, i, beat_idx[i], beat_data[i], beat_last[i],
                 i, mem[i], (i == NC - 1));
      end
    end
    for (int i = 0; i < oe_addr.size() && i < NC; i++) begin
      n_checks++;
      if (oe_addr[i] !== AW'(i)) begin
        n_fail++;
        $display("FAIL %s rd_addr%0d: got %0d want %0d", tag, i, oe_addr[i], i);
      end
    end
    n_checks++;
    if (done_n != 1) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d want 1", tag, done_n);
    end
  endtask

  task automatic check_result(input string tag, input logic [AW-1:0] id,
                              input logic [DW-1:0] sc);
    n_checks++;
    if (class_id !== id || class_score !== sc) begin
      n_fail++;
      $display("FAIL %s argmax: got id=%0d score=%h want id=%0d score=%h",
               tag, class_id, class_score, id, sc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({oe_L2, out_valid, out_last, done} !== 4'b0 || addr_L2 !== '0 ||
        out_data !== '0 || out_idx !== '0 || class_id !== '0 ||
        class_score !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got oe=%b v=%b last=%b done=%b data=%h id=%0d sc=%h want all 0",
               oe_L2, out_valid, out_last, done, out_data, class_id, class_score);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_stats();
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (oe_addr.size() != 0 || done_n != 0) begin
      n_fail++;
      $display("FAIL busy_low_from_reset: got oe=%0d done=%0d want 0 0",
               oe_addr.size(), done_n);
    end
  endtask

  task automatic test_basic();
    int cyc;
    bit ok;
    load('{5, -3, 100, 7, 0, -1, 99, 2, 3, 4});
    out_ready = 1'b1;
    clear_stats();
    start_and_wait(cyc, ok);
    n_checks++;
    if (!ok || cyc != 31) begin
      n_fail++;
      $display("FAIL basic_latency: got ok=%b cycles=%0d want 1 31", ok, cyc);
    end
    check_stream("basic");
    check_result("basic", 4'd2, 32'd100);
  endtask

  task automatic test_negative();
    int cyc;
    bit ok;
    load('{-10, -2, -7, -20, -30, -15, -40, -3, -25, -50});
    out_ready = 1'b1;
    clear_stats();
    start_and_wait(cyc, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL neg_timeout: got no done want done");
    end
    check_stream("neg");
    check_result("neg", 4'd1, 32'hFFFF_FFFE);
  endtask

  task automatic test_ties_and_last();
    int cyc;
    bit ok;
    load('{8, 8, 3, 8, 8, 1, 8, 0, 8, 8});
    out_ready = 1'b1;
    clear_stats();
    start_and_wait(cyc, ok);
    check_stream("ties");
    check_result("ties", 4'd0, 32'd8);
    load('{32'h8000_0000, 5, 32'h7FFF_FFFE, -1, 0, 9, 12, 3, 32'h7FFF_FFFE,
           32'h7FFF_FFFF});
    clear_stats();
    start_and_wait(cyc, ok);
    check_stream("maxlast");
    check_result("maxlast", 4'd9, 32'h7FFF_FFFF);
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    load('{5, -3, 100, 7, 0, -1, 99, 2, 3, 4});
    out_ready = 1'b0;
    clear_stats();
    rand_mode = 1'b1;
    start_and_wait(cyc, ok);
    rand_mode = 1'b0;
    #2;
    out_ready = 1'b1;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_timeout: got no done want done");
    end
    n_checks++;
    if (stab_err != 0) begin
      n_fail++;
      $display("FAIL bp_stability: got %0d unstable cycles want 0", stab_err);
    end
    check_stream("bp");
    check_result("bp", 4'd2, 32'd100);
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    bit hit;
    load('{5, -3, 100, 7, 0, -1, 99, 2, 3, 4});
    out_ready = 1'b1;
    clear_stats();
    busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    busy = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (out_valid && out_idx == 4'd4) begin
        out_ready = 1'b0;
        hit = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (!hit || !out_valid || out_idx !== 4'd4 || out_data !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_stall: got hit=%b v=%b idx=%0d data=%h want 1 1 4 0",
               hit, out_valid, out_idx, out_data);
    end
    reset = 1'b1;
    #2;
    n_checks++;
    if ({oe_L2, out_valid, out_last, done} !== 4'b0 || out_data !== '0 ||
        out_idx !== '0 || class_id !== '0 || class_score !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got oe=%b v=%b idx=%0d id=%0d sc=%h want all 0",
               oe_L2, out_valid, out_idx, class_id, class_score);
    end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (done_n != 0 || oe_addr.size() != 5) begin
      n_fail++;
      $display("FAIL mid_no_done: got done=%0d oe=%0d want 0 5",
               done_n, oe_addr.size());
    end
    load('{-10, -2, -7, -20, -30, -15, -40, -3, -25, -50});
    clear_stats();
    start_and_wait(cyc, ok);
    n_checks++;
    if (!ok || cyc != 31) begin
      n_fail++;
      $display("FAIL mid_rerun: got ok=%b cycles=%0d want 1 31", ok, cyc);
    end
    check_stream("rerun");
    check_result("rerun", 4'd1, 32'hFFFF_FFFE);
  endtask

  task automatic test_busy_glitch();
    bit ok;
    load('{1, 2, 3, 4, 5, 6, 7, 60, 9, 10});
    out_ready = 1'b1;
    clear_stats();
    busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    busy = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    busy = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (60) @(posedge clk);
    #1;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL glitch_timeout: got no done want done");
    end
    check_stream("glitch");
    check_result("glitch", 4'd7, 32'd60);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_ties_and_last();
    test_backpressure();
    test_reset_mid();
    test_busy_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
